// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode constants, line/frame total helper,
// and the region classification used by both raster axes.
// Latency: n/a (package). Backpressure: n/a.
// Contents: region_t {SYNC, BACK, ACTIVE, FRONT}, VGA640_* and VGA800_* constants,
// total(), region_of().
package vga_timing_pkg;

  // Order matches the raster order within a line and within a frame.
  typedef enum logic [1:0] {SYNC, BACK, ACTIVE, FRONT} region_t;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs.
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  function automatic int total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  // Classify a position along one axis; anything past the active span is front porch.
  function automatic region_t region_of(input int pos, input int sync, input int bp,
                                        input int active);
    region_t r;
    if (pos < sync)                    r = SYNC;
    else if (pos < sync + bp)          r = BACK;
    else if (pos < sync + bp + active) r = ACTIVE;
    else                               r = FRONT;
    return r;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and region decode.
// Latency: cnt updates on the clk where step=1; wrap/in_sync/in_active are combinational from cnt.
// Backpressure: none; the counter only moves when step=1.
// Ports: clk, rst (sync, active-high), step -> cnt[CNT_W], wrap (step on last position),
//        in_sync, in_active (decode of the current cnt).
// Package items are referenced by scope here because the SYNC/ACTIVE parameter names
// would otherwise collide with the region enum literals.
module vga_axis_counter #(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);

  localparam int TOTAL = vga_timing_pkg::total(SYNC, BP, ACTIVE, FP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if ((2 ** CNT_W) < TOTAL) begin : g_width_check
    $error("vga_axis_counter: CNT_W too narrow for axis total");
  end

  vga_timing_pkg::region_t rgn;

  assign wrap = step && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rgn       = vga_timing_pkg::region_of(int'(cnt), SYNC, BP, ACTIVE);
    in_sync   = (rgn == vga_timing_pkg::SYNC);
    in_active = (rgn == vga_timing_pkg::ACTIVE);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync pulses, data-enable, active coordinates, line/frame strobes.
// Latency: outputs are the registered decode of the counters, one pix_ce step behind them.
// Backpressure: none; pix_ce=0 freezes everything and forces the strobes low.
// Ports: clk, rst (sync, active-high, wins over pix_ce), pix_ce -> hsync, vsync, de,
//        x[CNT_W], y[CNT_W], line_start, frame_start, frame_cnt[16] (VGA_FRAME_CNT_EN only).
// Optional feature macro: VGA_FRAME_CNT_EN adds the completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] H_OFF = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_OFF = CNT_W'(V_SYNC + V_BP);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap, h_in_sync, v_in_sync, h_in_active, v_in_active;
  logic v_step, act, at_origin;

  assign v_step = pix_ce & h_wrap;
  assign act    = h_in_active & v_in_active;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk(clk), .rst(rst), .step(pix_ce),
    .cnt(h_cnt), .wrap(h_wrap), .in_sync(h_in_sync), .in_active(h_in_active)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk(clk), .rst(rst), .step(v_step),
    .cnt(v_cnt), .wrap(v_wrap), .in_sync(v_in_sync), .in_active(v_in_active)
  );

  // Set exactly while the counters sit at (0,0): after reset and after a frame wrap,
  // cleared by the next step. Avoids a second full-width compare on v.
  always_ff @(posedge clk) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else if (pix_ce) begin
      at_origin <= v_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are one clk wide even when pix_ce is sparse.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync       <= h_in_sync ? HS_POL : ~HS_POL;
        vsync       <= v_in_sync ? VS_POL : ~VS_POL;
        de          <= act;
        x           <= act ? h_cnt - H_OFF : '0;
        y           <= act ? v_cnt - V_OFF : '0;
        line_start  <= (h_cnt == '0);
        frame_start <= at_origin;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // The first frame_start after reset opens frame 0, so it does not count as completed.
  logic seen_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= '0;
      seen_frame <= 1'b0;
    end else if (pix_ce && at_origin) begin
      seen_frame <= 1'b1;
      if (seen_frame) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
